button_event_queue: RTL and testbench

Memory-mapped input peripheral that answers processor loads from the data-memory bus. It debounces the four push-buttons (U, R, D, L) and turns each stable level change into an event word. Events are held in a small FIFO, and game code polls them through two MMIO addresses. The block sits beside RAM in the top-level wrapper: its `rdata` is muxed onto the processor's `q_dmem` whenever `hit` is high.

---
 rtl/button_event_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 27 ++
 rtl/button_event_queue.sv | 76 +++++++
 tb/tb_button_event_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// button_event_pkg: button ids, MMIO word field positions, default addresses and word builders
// shared by button_event_queue and its testbench.
package button_event_pkg;
   localparam logic [1:0] BTN_U = 2'd0;
   localparam logic [1:0] BTN_R = 2'd1;
   localparam logic [1:0] BTN_D = 2'd2;
   localparam logic [1:0] BTN_L = 2'd3;
   localparam int EV_VALID_BIT = 31;
   localparam int EV_PRESS_BIT = 2;
   localparam int EV_ID_LSB = 0;
   localparam int ST_OVF_BIT = 31;
   localparam int ST_COUNT_MSB = 15;
   localparam logic [11:0] DEF_STATUS_ADDR = 12'd2;
   localparam logic [11:0] DEF_DATA_ADDR = 12'd3;
   function automatic logic [31:0] ev_word(input logic press, input logic [1:0] id);
      ev_word = '0;
      ev_word[EV_VALID_BIT] = 1'b1;
      ev_word[EV_PRESS_BIT] = press;
      ev_word[EV_ID_LSB+:2] = id;
   endfunction
   function automatic logic [31:0] st_word(input logic ovf, input logic [15:0] count);
      st_word = '0;
      st_word[ST_OVF_BIT] = ovf;
      st_word[ST_COUNT_MSB:0] = count;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stability counter; change strobes the cycle stable flips.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic change
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic meta, sync;
   logic [CW-1:0] cnt;
   assign change = sync != stable && cnt == CW'(DEBOUNCE_CYCLES - 1);
   always_ff @(posedge clock)
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         stable <= 1'b0;
         cnt <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         stable <= change ? sync : stable;
         cnt <= change || sync == stable ? '0 : cnt + 1'b1;
      end
endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: debounced U/R/D/L buttons feeding an MMIO-polled event FIFO.
// Define BUTTON_EVENT_RELEASE_EN to queue release events as well as presses.
module button_event_queue
   import button_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DEPTH = 8,
   parameter logic [11:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter logic [11:0] DATA_ADDR = DEF_DATA_ADDR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  btn_raw,
   input  logic [11:0] mem_addr,
   input  logic        mem_we,
   output logic [31:0] rdata,
   output logic        hit
);
   localparam int AW = $clog2(DEPTH);
   logic [3:0] stable, change, pending, set, grant;
   logic [1:0] sel;
   logic press, push, pop, clr, full, accept, drop, is_data, is_status, overflow;
   logic [2:0] mem [DEPTH];
   logic [2:0] head;
   logic [AW-1:0] wp, rp;
   logic [AW:0] count;
   for (genvar i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock(clock),
         .reset(reset),
         .raw(btn_raw[i]),
         .stable(stable[i]),
         .change(change[i])
      );
   end
   always_comb begin
      sel = pending[0] ? BTN_U : pending[1] ? BTN_R : pending[2] ? BTN_D : BTN_L;
      push = |pending;
      grant = push ? 4'b1 << sel : 4'b0;
`ifdef BUTTON_EVENT_RELEASE_EN
      set = change;
      press = stable[sel];
`else
      set = change & ~stable;
      press = 1'b1;
`endif
      is_data = mem_addr == DATA_ADDR;
      is_status = mem_addr == STATUS_ADDR;
      pop = mem_we && is_data && count != '0;
      clr = mem_we && is_status;
      full = count == (AW+1)'(DEPTH);
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      accept = push && (!full || pop);
      drop = push && full && !pop;
      head = mem[rp];
   end
   assign hit = is_data || is_status;
   assign rdata = is_data ? (count != '0 ? ev_word(head[2], head[1:0]) : '0) :
                  is_status ? st_word(overflow, 16'(count)) : '0;
   always_ff @(posedge clock)
      if (!reset) begin
         pending <= '0;
         wp <= '0;
         rp <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~grant) | set;
         wp <= wp + AW'(accept);
         rp <= rp + AW'(pop);
         count <= count + (AW+1)'(accept) - (AW+1)'(pop);
         overflow <= drop || (overflow && !clr);
      end
   always_ff @(posedge clock)
      if (accept) mem[wp] <= {press, sel};
endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: directed scenarios plus random button/MMIO traffic scored against a
// history-based reference model of debounce, arbitration and the event FIFO.
module tb_button_event_queue;
   localparam int DC = 4;
   localparam int DEPTH = 4;
   localparam logic [11:0] ST = 12'd2;
   localparam logic [11:0] DA = 12'd3;
`ifdef BUTTON_EVENT_RELEASE_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b0, mem_we = 1'b0;
   logic [3:0] btn_raw = '0;
   logic [11:0] mem_addr = '0;
   logic [31:0] rdata;
   logic hit;
   int errors = 0, checks = 0;
   always #5 clock = ~clock;
   button_event_queue #(.DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH), .STATUS_ADDR(ST), .DATA_ADDR(DA)) dut (
      .clock(clock),
      .reset(reset),
      .btn_raw(btn_raw),
      .mem_addr(mem_addr),
      .mem_we(mem_we),
      .rdata(rdata),
      .hit(hit)
   );
   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endfunction
   // reference model: raw samples per edge, accepted levels, pending set and the expected FIFO
   logic [3:0] hist[$];
   int fresh[4];
   logic [3:0] st_m = '0, pend_m = '0;
   logic [31:0] exp_q[$];
   bit ovf_m = 1'b0;
   always @(posedge clock) begin : model
      int t, id;
      bit ok;
      t = hist.size();
      if (!reset) begin
         st_m = '0;
         pend_m = '0;
         ovf_m = 1'b0;
         exp_q.delete();
         for (int b = 0; b < 4; b++) fresh[b] = t + 1;
         hist.push_back(4'b0);
      end else begin
         if (mem_we && mem_addr == DA && exp_q.size() > 0) void'(exp_q.pop_front());
         if (mem_we && mem_addr == ST) ovf_m = 1'b0;
         if (pend_m != 0) begin
            id = 0;
            while (!pend_m[id]) id++;
            pend_m[id] = 1'b0;
            if (exp_q.size() < DEPTH) exp_q.push_back({1'b1, 28'b0, (REL ? st_m[id] : 1'b1), 2'(id)});
            else ovf_m = 1'b1;
         end
         // a level is accepted once the last DC synchronized samples all differ from it
         for (int b = 0; b < 4; b++)
            if (t - 1 - DC >= fresh[b]) begin
               ok = 1'b1;
               for (int k = t - 1 - DC; k <= t - 2; k++) if (hist[k][b] == st_m[b]) ok = 1'b0;
               if (ok) begin
                  st_m[b] = ~st_m[b];
                  fresh[b] = t - 1;
                  if (REL || st_m[b]) pend_m[b] = 1'b1;
               end
            end
         hist.push_back(btn_raw);
      end
   end
   always @(negedge clock) begin : monitor
      logic [31:0] exp;
      exp = mem_addr == DA ? (exp_q.size() > 0 ? exp_q[0] : 32'h0) :
            mem_addr == ST ? {ovf_m, 15'b0, 16'(exp_q.size())} : 32'h0;
      chk("mon_rdata", rdata, exp);
      chk("mon_hit", {31'b0, hit}, {31'b0, mem_addr == DA || mem_addr == ST});
   end
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic expect_rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
      mem_addr = a;
      mem_we = 1'b0;
      @(negedge clock);
      chk(nm, rdata, exp);
      @(posedge clock);
      #1;
   endtask
   task automatic wr(input logic [11:0] a);
      mem_addr = a;
      mem_we = 1'b1;
      @(posedge clock);
      #1;
      mem_we = 1'b0;
      mem_addr = '0;
   endtask
   initial begin
      logic [11:0] addrs[4];
      addrs = '{12'h000, ST, DA, 12'h803};
      idle(2);
      expect_rd(DA, 32'h0, "reset_data");
      expect_rd(ST, 32'h0, "reset_status");
      reset = 1'b1;
      idle(1);
      btn_raw = 4'b0001;
      idle(7);
      expect_rd(DA, 32'h8000_0004, "u_press_data");
      expect_rd(ST, 32'h0000_0001, "u_press_status");
      wr(DA);
      expect_rd(DA, 32'h0, "u_popped");
      btn_raw = 4'b0000;
      idle(10);
`ifdef BUTTON_EVENT_RELEASE_EN
      expect_rd(DA, 32'h8000_0000, "u_release");
      wr(DA);
`endif
      btn_raw = 4'b1000;
      idle(3);
      btn_raw = 4'b0000;
      idle(10);
      expect_rd(ST, 32'h0, "l_glitch");
      btn_raw = 4'b0110;
      idle(7);
      expect_rd(DA, 32'h8000_0005, "rd_first");
      expect_rd(ST, 32'h0000_0002, "rd_count");
      btn_raw = 4'b0000;
      idle(10);
      repeat (4) wr(DA);
      expect_rd(ST, 32'h0, "rd_drained");
      btn_raw = 4'b1111;
      idle(10);
      btn_raw = 4'b0000;
      idle(10);
      btn_raw = 4'b0001;
      idle(10);
      expect_rd(ST, 32'h8000_0004, "ovf_set");
      wr(ST);
      expect_rd(ST, 32'h0000_0004, "ovf_cleared");
      btn_raw = 4'b0000;
      idle(10);
      wr(ST);
      expect_rd(ST, 32'h0000_0004, "full_no_ovf");
      btn_raw = 4'b0010;
      idle(6);
      wr(DA);
      expect_rd(ST, 32'h0000_0004, "push_pop_full");
      expect_rd(DA, 32'h8000_0005, "head_after_pop");
      repeat (3) wr(DA);
      expect_rd(DA, 32'h8000_0005, "tail_event");
      wr(DA);
      expect_rd(ST, 32'h0, "drained");
      wr(DA);
      expect_rd(ST, 32'h0, "pop_empty");
      btn_raw = 4'b0000;
      idle(10);
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
         mem_addr = addrs[$urandom_range(3)];
         mem_we = $urandom_range(3) == 0;
         idle(1);
      end
      mem_we = 1'b0;
      mem_addr = DA;
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
